ibex_lsu_resp_unit: RTL and testbench

IBEX_LSU_RESP_UNIT -- requirements
Module: ibex_lsu_resp_unit

---
 rtl/ibex_lsu_resp_unit_if.sv | 23 ++
 rtl/ibex_lsu_resp_unit.sv | 180 ++++++++++++++++++
 tb/tb_ibex_lsu_resp_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_lsu_resp_unit_if.sv
// Data-bus bundle between the LSU response unit (master) and the memory
// side (slave).
interface ibex_lsu_resp_unit_if;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/ibex_lsu_resp_unit.sv
// Single-outstanding load/store unit: accepts one request, runs one bus
// transaction, and returns a one-cycle response with optional wait timeout.
module ibex_lsu_resp_unit #(
  parameter logic [15:0] BusTimeout = 16'd0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        lsu_req_i,
  input  logic                        lsu_we_i,
  input  logic [1:0]                  lsu_type_i,
  input  logic                        lsu_sign_ext_i,
  input  logic [31:0]                 lsu_addr_i,
  input  logic [31:0]                 lsu_wdata_i,
  output logic                        lsu_req_ready_o,
  ibex_lsu_resp_unit_if.master        bus,
  output logic                        lsu_resp_valid_o,
  output logic                        lsu_resp_err_o,
  output logic                        rf_we_lsu_o,
  output logic [31:0]                 rf_wdata_lsu_o,
  output logic                        busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    MISALIGN = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  state_e      state_r;
  logic [31:0] addr_r;
  logic        we_r;
  logic [1:0]  type_r;
  logic        sext_r;
  logic [31:0] wdata_r;
  logic [15:0] cnt_r;

  logic        misalign_s;
  logic        timeout_s;
  logic        resp_valid_s;
  logic        resp_err_s;
  logic        rf_we_s;
  logic [4:0]  shift_s;
  logic [31:0] shifted_s;
  logic [31:0] load_s;
  logic [3:0]  be_s;
  logic        in_req_s;

  // Request classification and timeout detection
  always_comb begin
    misalign_s = 1'b0;
    case (lsu_type_i)
      2'b01:   misalign_s = lsu_addr_i[0];
      2'b10:   misalign_s = 1'b0;
      default: misalign_s = (lsu_addr_i[1:0] != 2'b00);
    endcase
    if ((BusTimeout != 16'd0) && (cnt_r == (BusTimeout - 16'd1)) && !bus.data_rvalid_i) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Response generation; rvalid takes priority over a coincident timeout
  always_comb begin
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    case (state_r)
      WAIT: begin
        if (bus.data_rvalid_i) begin
          resp_valid_s = 1'b1;
          resp_err_s   = bus.data_err_i;
        end else if (timeout_s) begin
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
        end else begin
          resp_valid_s = 1'b0;
          resp_err_s   = 1'b0;
        end
      end
      MISALIGN: begin
        resp_valid_s = 1'b1;
        resp_err_s   = 1'b1;
      end
      default: begin
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
      end
    endcase
    rf_we_s = resp_valid_s & ~resp_err_s & ~we_r;
  end

  // Load alignment and extension; words only reach WAIT aligned, so the
  // shifted value equals the raw read data there
  always_comb begin
    shift_s   = {addr_r[1:0], 3'b000};
    shifted_s = bus.data_rdata_i >> shift_s;
    load_s    = 32'd0;
    case (type_r)
      2'b10:   load_s = sext_r ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                               : {24'd0, shifted_s[7:0]};
      2'b01:   load_s = sext_r ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                               : {16'd0, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
  end

  // Byte-enable decode from captured type and offset
  always_comb begin
    be_s = 4'b0000;
    case (type_r)
      2'b10:   be_s = 4'b0001 << addr_r[1:0];
      2'b01:   be_s = 4'b0011 << addr_r[1:0];
      default: be_s = 4'b1111;
    endcase
  end

  assign in_req_s         = (state_r == REQ);
  assign lsu_req_ready_o  = (state_r == IDLE);
  assign busy_o           = (state_r != IDLE);
  assign bus.data_req_o   = in_req_s;
  assign bus.data_addr_o  = in_req_s ? {addr_r[31:2], 2'b00} : 32'd0;
  assign bus.data_we_o    = in_req_s ? we_r : 1'b0;
  assign bus.data_be_o    = in_req_s ? be_s : 4'b0000;
  assign bus.data_wdata_o = in_req_s ? (wdata_r << shift_s) : 32'd0;
  assign lsu_resp_valid_o = resp_valid_s;
  assign lsu_resp_err_o   = resp_err_s;
  assign rf_we_lsu_o      = rf_we_s;
  assign rf_wdata_lsu_o   = rf_we_s ? load_s : 32'd0;

  // Transaction FSM, request capture and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
      we_r    <= 1'b0;
      type_r  <= 2'b00;
      sext_r  <= 1'b0;
      wdata_r <= 32'd0;
      cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (lsu_req_i) begin
            addr_r  <= lsu_addr_i;
            we_r    <= lsu_we_i;
            type_r  <= lsu_type_i;
            sext_r  <= lsu_sign_ext_i;
            wdata_r <= lsu_wdata_i;
            state_r <= misalign_s ? MISALIGN : REQ;
          end
        end
        REQ: begin
          if (bus.data_gnt_i) begin
            cnt_r   <= 16'd0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (bus.data_rvalid_i) begin
            state_r <= IDLE;
          end else if (timeout_s) begin
            state_r <= DRAIN;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        MISALIGN: state_r <= IDLE;
        DRAIN: begin
          if (bus.data_rvalid_i) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Vector table plus response scoreboard for ibex_lsu_resp_unit (BusTimeout=4).
module tb_ibex_lsu_resp_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_req_ready_o, lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o, busy_o;
  logic [31:0] rf_wdata_lsu_o;

  ibex_lsu_resp_unit_if bus_if ();

  ibex_lsu_resp_unit #(.BusTimeout(16'd4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_req_ready_o(lsu_req_ready_o), .bus(bus_if),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o),
    .rf_we_lsu_o(rf_we_lsu_o), .rf_wdata_lsu_o(rf_wdata_lsu_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        derr;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        eerr;
    logic        erf_we;
    logic [31:0] erf_wdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        rf_we;
    logic [31:0] rf_wdata;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_r;
  vec_t  vt[13];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic we, logic [1:0] typ, logic sext, logic [31:0] addr,
                              logic [31:0] wdata, int gd, int rd, logic [31:0] rdata,
                              logic derr, logic mis, logic [3:0] be, logic [31:0] baddr,
                              logic [31:0] bwdata, logic eerr, logic erf_we,
                              logic [31:0] erf_wdata);
    vec_t v;
    v.we = we; v.typ = typ; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.gnt_dly = gd; v.rv_dly = rd; v.rdata = rdata; v.derr = derr; v.mis = mis;
    v.be = be; v.baddr = baddr; v.bwdata = bwdata; v.eerr = eerr;
    v.erf_we = erf_we; v.erf_wdata = erf_wdata;
    return v;
  endfunction

  task automatic drive_req(input logic we, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ;
    lsu_sign_ext_i = sext; lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(negedge clk);
    chk("ready", 32'(lsu_req_ready_o), 32'd1);
    step();
    lsu_req_i = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    resp_t e;
    e.err = v.eerr; e.rf_we = v.erf_we; e.rf_wdata = v.erf_wdata;
    exp_q.push_back(e);
    drive_req(v.we, v.typ, v.sext, v.addr, v.wdata);
    if (v.mis) begin
      @(negedge clk);
      chk("mis_no_req", 32'(bus_if.data_req_o), 32'd0);
      chk("mis_valid", 32'(lsu_resp_valid_o), 32'd1);
      step();
    end else begin
      for (int g = 0; g <= v.gnt_dly; g++) begin
        bus_if.data_gnt_i = (g == v.gnt_dly);
        @(negedge clk);
        chk("bus_req", 32'(bus_if.data_req_o), 32'd1);
        chk("bus_addr", bus_if.data_addr_o, v.baddr);
        chk("bus_be", 32'(bus_if.data_be_o), 32'(v.be));
        chk("bus_wdata", bus_if.data_wdata_o, v.bwdata);
        chk("bus_we", 32'(bus_if.data_we_o), 32'(v.we));
        step();
      end
      bus_if.data_gnt_i = 1'b0;
      for (int r = 0; r <= v.rv_dly; r++) begin
        bus_if.data_rvalid_i = (r == v.rv_dly);
        bus_if.data_rdata_i  = v.rdata;
        bus_if.data_err_i    = v.derr;
        @(negedge clk);
        chk("resp_timing", 32'(lsu_resp_valid_o), 32'(r == v.rv_dly));
        step();
      end
      bus_if.data_rvalid_i = 1'b0;
      bus_if.data_err_i    = 1'b0;
    end
  endtask

  // Scoreboard: every response pops one expectation; otherwise outputs stay quiet
  always @(negedge clk) begin
    if (lsu_resp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        exp_r = exp_q.pop_front();
        chk("resp_err", 32'(lsu_resp_err_o), 32'(exp_r.err));
        chk("rf_we", 32'(rf_we_lsu_o), 32'(exp_r.rf_we));
        chk("rf_wdata", rf_wdata_lsu_o, exp_r.rf_wdata);
      end
    end else begin
      chk("quiet", {29'd0, lsu_resp_err_o, rf_we_lsu_o, |rf_wdata_lsu_o}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
    bus_if.data_gnt_i = 1'b0; bus_if.data_rvalid_i = 1'b0;
    bus_if.data_err_i = 1'b0; bus_if.data_rdata_i = 32'd0;

    vt[0]  = mk(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 2, 1, 32'h80FF_FF12, 1'b0, 1'b0,
                4'h8, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    vt[1]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h1234_5678, 1'b0, 1'b0,
                4'hC, 32'h0000_2000, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0);
    vt[2]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1,
                4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    vt[3]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 1, 2, 32'hDEAD_BEEF, 1'b1, 1'b0,
                4'hF, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 32'h0);
    vt[4]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_5002, 32'h0, 0, 1, 32'h8765_4321, 1'b0, 1'b0,
                4'hC, 32'h0000_5000, 32'h0, 1'b0, 1'b1, 32'h0000_8765);
    vt[5]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 1, 3, 32'h8765_4321, 1'b0, 1'b0,
                4'hC, 32'h0000_5000, 32'h0, 1'b0, 1'b1, 32'hFFFF_8765);
    vt[6]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_6001, 32'h0, 0, 0, 32'h0000_A500, 1'b0, 1'b0,
                4'h2, 32'h0000_6000, 32'h0, 1'b0, 1'b1, 32'h0000_00A5);
    vt[7]  = mk(1'b0, 2'b11, 1'b0, 32'h0000_7000, 32'h0, 1, 1, 32'hCAFE_F00D, 1'b0, 1'b0,
                4'hF, 32'h0000_7000, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    vt[8]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_8002, 32'h0000_00AB, 0, 0, 32'h0, 1'b0, 1'b0,
                4'h4, 32'h0000_8000, 32'h00AB_0000, 1'b0, 1'b0, 32'h0);
    vt[9]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_9001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1,
                4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    vt[10] = mk(1'b1, 2'b00, 1'b0, 32'h0000_A000, 32'h1122_3344, 2, 2, 32'hFFFF_FFFF, 1'b0, 1'b0,
                4'hF, 32'h0000_A000, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    vt[11] = mk(1'b0, 2'b10, 1'b1, 32'h0000_B000, 32'h0, 0, 0, 32'h1234_567F, 1'b0, 1'b0,
                4'h1, 32'h0000_B000, 32'h0, 1'b0, 1'b1, 32'h0000_007F);
    vt[12] = mk(1'b0, 2'b11, 1'b0, 32'h0000_C002, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1,
                4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req", 32'(bus_if.data_req_o), 32'd0);
    chk("rst_addr", bus_if.data_addr_o, 32'd0);
    chk("rst_be_wdata", {28'd0, bus_if.data_be_o} | bus_if.data_wdata_o, 32'd0);
    step();
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) do_txn(vt[i]);
    @(negedge clk);
    chk("ready_after_mis", 32'(lsu_req_ready_o), 32'd1);
    step();

    // Timeout: four silent WAIT cycles, then a late rvalid swallowed in DRAIN
    exp_r.err = 1'b1; exp_r.rf_we = 1'b0; exp_r.rf_wdata = 32'd0;
    exp_q.push_back(exp_r);
    drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0C00, 32'h0);
    bus_if.data_gnt_i = 1'b1;
    step();
    bus_if.data_gnt_i = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      chk("to_valid", 32'(lsu_resp_valid_o), 32'(w == 4));
      step();
    end
    for (int d = 1; d <= 3; d++) begin
      bus_if.data_rvalid_i = (d == 3);
      @(negedge clk);
      chk("drain_busy", 32'(busy_o), 32'd1);
      chk("drain_silent", 32'(lsu_resp_valid_o), 32'd0);
      step();
    end
    bus_if.data_rvalid_i = 1'b0;
    @(negedge clk);
    chk("drain_done", 32'(busy_o), 32'd0);
    step();

    // Reset while in WAIT abandons the transaction; stray rvalid ignored
    drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0D00, 32'h0);
    bus_if.data_gnt_i = 1'b1;
    step();
    bus_if.data_gnt_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("wrst_busy", 32'(busy_o), 32'd0);
    chk("wrst_req", 32'(bus_if.data_req_o), 32'd0);
    chk("wrst_addr", bus_if.data_addr_o, 32'd0);
    step();
    bus_if.data_rvalid_i = 1'b1;
    bus_if.data_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_valid", 32'(lsu_resp_valid_o), 32'd0);
    chk("stray_busy", 32'(busy_o), 32'd0);
    step();
    bus_if.data_rvalid_i = 1'b0;
    do_txn(vt[0]);

    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
